// File: rtl/scrambler_partition_pipe.sv
// Purpose: scrambles TCDM request addresses (stack swizzle or programmable heap partitions).
// Latency: 2 cycles from request accept to rsp_valid_o, 1 result per cycle when not stalled.
// Backpressure: valid/ready on both sides; req_ready_o drops only when both stages are full or a config write is accepted.
//
// Ports:
//   clk_i, rst_i                    clock, synchronous active-high reset
//   cfg_valid_i/cfg_ready_o         config write handshake (ready only with an empty pipe)
//   cfg_idx_i, cfg_start_i,
//   cfg_rows_i, cfg_group_i         partition entry index, base, row count R, group factor G
//   cfg_err_o                       sticky flag, set by any invalid config write
//   req_valid_i/req_ready_o/req_addr_i   input request
//   rsp_valid_o/rsp_ready_i/rsp_addr_o/rsp_region_o  scrambled output and region code
module scrambler_partition_pipe #(
    parameter int AddrWidth         = 32,
    parameter int ByteOffset        = 2,
    parameter int NumTiles          = 128,
    parameter int NumBanksPerTile   = 16,
    parameter int SeqMemSizePerTile = 2048,
    parameter int NumPartitions     = 4,
    localparam int IdxW = (NumPartitions > 1) ? $clog2(NumPartitions) : 1,
    localparam int RegW = $clog2(NumPartitions + 2)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 cfg_valid_i,
    output logic                 cfg_ready_o,
    input  logic [IdxW-1:0]      cfg_idx_i,
    input  logic [AddrWidth-1:0] cfg_start_i,
    input  logic [7:0]           cfg_rows_i,
    input  logic [7:0]           cfg_group_i,
    output logic                 cfg_err_o,
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    input  logic [AddrWidth-1:0] req_addr_i,
    output logic                 rsp_valid_o,
    input  logic                 rsp_ready_i,
    output logic [AddrWidth-1:0] rsp_addr_o,
    output logic [RegW-1:0]      rsp_region_o
);
    localparam int T       = $clog2(NumTiles);
    localparam int C       = ByteOffset + $clog2(NumBanksPerTile);
    localparam int S       = $clog2(SeqMemSizePerTile) - C;
    localparam int RowBits = C + T;
    localparam logic [AddrWidth:0]   StackLimit = (AddrWidth+1)'(NumTiles * SeqMemSizePerTile);
    localparam logic [AddrWidth-1:0] AllOnes    = '1;

    // Log2 of a one-hot byte.
    function automatic logic [3:0] log2_8(input logic [7:0] v);
        log2_8 = '0;
        for (int i = 0; i < 8; i++) begin
            if (v[i]) log2_8 = 4'(i);
        end
    endfunction

    // Partition table
    logic [NumPartitions-1:0] part_en;
    logic [AddrWidth-1:0]     part_start [NumPartitions];
    logic [AddrWidth:0]       part_limit [NumPartitions];
    logic [3:0]               part_r     [NumPartitions];
    logic [3:0]               part_g     [NumPartitions];

    // Pipeline state
    logic                 s1_valid;
    logic [AddrWidth-1:0] s1_addr;
    logic [RegW-1:0]      s1_region;
    logic [AddrWidth-1:0] s1_start;
    logic [3:0]           s1_r;
    logic [3:0]           s1_g;

    // Handshake
    logic cfg_accept, req_accept, s1_load, s1_advance, s2_load;

    assign s2_load     = !rsp_valid_o || rsp_ready_i;
    assign s1_advance  = s1_valid && s2_load;
    assign s1_load     = !s1_valid || s1_advance;
    assign cfg_ready_o = !s1_valid && !rsp_valid_o;
    assign cfg_accept  = cfg_valid_i && cfg_ready_o;
    assign req_ready_o = s1_load && !cfg_accept;
    assign req_accept  = req_valid_i && req_ready_o;

    // Config validation. R = 0 is a legal disable regardless of the other fields.
    logic               rows_pow2, group_ok, start_ok, cfg_ok, cfg_en;
    logic [AddrWidth:0] cfg_limit;

    always_comb begin
        rows_pow2 = (cfg_rows_i & (cfg_rows_i - 8'd1)) == 8'd0;
        group_ok  = (cfg_group_i != 8'd0) && ((cfg_group_i & (cfg_group_i - 8'd1)) == 8'd0)
                    && (32'(cfg_group_i) <= 32'(NumTiles));
        start_ok  = cfg_start_i[RowBits-1:0] == '0;
        cfg_ok    = (cfg_rows_i == 8'd0) || (rows_pow2 && group_ok && start_ok);
        cfg_en    = cfg_ok && (cfg_rows_i != 8'd0);
        // One extra bit so a partition ending at the top of memory does not wrap.
        cfg_limit = {1'b0, cfg_start_i} + ((AddrWidth+1)'(cfg_rows_i) << RowBits);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            part_en   <= '0;
            cfg_err_o <= 1'b0;
            for (int p = 0; p < NumPartitions; p++) begin
                part_start[p] <= '0;
                part_limit[p] <= '0;
                part_r[p]     <= '0;
                part_g[p]     <= '0;
            end
        end else if (cfg_accept) begin
            if (!cfg_ok) cfg_err_o <= 1'b1;
            for (int p = 0; p < NumPartitions; p++) begin
                if (cfg_idx_i == IdxW'(p)) begin
                    part_en[p]    <= cfg_en;
                    part_start[p] <= cfg_start_i;
                    part_limit[p] <= cfg_limit;
                    part_r[p]     <= log2_8(cfg_rows_i);
                    part_g[p]     <= log2_8(cfg_group_i);
                end
            end
        end
    end

    // Stage 1 region lookup: stack first, then lowest-index enabled partition.
    logic                 hit_found;
    logic [RegW-1:0]      hit_region;
    logic [AddrWidth-1:0] hit_start;
    logic [3:0]           hit_r, hit_g;

    always_comb begin
        hit_found  = 1'b0;
        hit_region = '0;
        hit_start  = '0;
        hit_r      = '0;
        hit_g      = '0;
        if ({1'b0, req_addr_i} < StackLimit) begin
            hit_found  = 1'b1;
            hit_region = RegW'(1);
        end
        for (int p = 0; p < NumPartitions; p++) begin
            if (!hit_found && part_en[p] && (req_addr_i >= part_start[p])
                && ({1'b0, req_addr_i} < part_limit[p])) begin
                hit_found  = 1'b1;
                hit_region = RegW'(p + 2);
                hit_start  = part_start[p];
                hit_r      = part_r[p];
                hit_g      = part_g[p];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_valid  <= 1'b0;
            s1_addr   <= '0;
            s1_region <= '0;
            s1_start  <= '0;
            s1_r      <= '0;
            s1_g      <= '0;
        end else begin
            if (s1_load) s1_valid <= req_accept;
            if (req_accept) begin
                s1_addr   <= req_addr_i;
                s1_region <= hit_region;
                s1_start  <= hit_start;
                s1_r      <= hit_r;
                s1_g      <= hit_g;
            end
        end
    end

    // Stage 2 address mapping. w holds the T+r word-index bits above the bank offset;
    // its low g bits and top T-g bits form the tile, the middle r bits the row.
    logic [AddrWidth-1:0] off, w, w_lo, w_hi, row, tile, part_addr, stack_addr, map_addr;
    logic [7:0]           sh_tr, sh_gr;

    always_comb begin
        off        = s1_addr - s1_start;
        sh_tr      = 8'(T) + {4'b0, s1_r};
        sh_gr      = {4'b0, s1_g} + {4'b0, s1_r};
        w          = (off >> C) & ~(AllOnes << sh_tr);
        w_lo       = w & ~(AllOnes << s1_g);
        row        = (w >> s1_g) & ~(AllOnes << s1_r);
        w_hi       = w >> sh_gr;
        tile       = (w_hi << s1_g) | w_lo;
        part_addr  = s1_start + (row << RowBits) + (tile << C) + (off & ~(AllOnes << C));
        stack_addr = s1_addr;
        stack_addr[C+S+T-1:C] = {s1_addr[C+S-1:C], s1_addr[C+S+T-1:C+S]};
        if (s1_region == RegW'(0))      map_addr = s1_addr;
        else if (s1_region == RegW'(1)) map_addr = stack_addr;
        else                            map_addr = part_addr;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rsp_valid_o  <= 1'b0;
            rsp_addr_o   <= '0;
            rsp_region_o <= '0;
        end else begin
            if (s2_load) rsp_valid_o <= s1_valid;
            if (s1_advance) begin
                rsp_addr_o   <= map_addr;
                rsp_region_o <= s1_region;
            end
        end
    end
endmodule

// File: tb/tb_scrambler_partition_pipe.sv
module tb_scrambler_partition_pipe;
    logic        clk;
    logic        rst_i;
    logic        cfg_valid_i;
    logic        cfg_ready_o;
    logic [1:0]  cfg_idx_i;
    logic [31:0] cfg_start_i;
    logic [7:0]  cfg_rows_i;
    logic [7:0]  cfg_group_i;
    logic        cfg_err_o;
    logic        req_valid_i;
    logic        req_ready_o;
    logic [31:0] req_addr_i;
    logic        rsp_valid_o;
    logic        rsp_ready_i;
    logic [31:0] rsp_addr_o;
    logic [2:0]  rsp_region_o;

    scrambler_partition_pipe dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .cfg_valid_i  (cfg_valid_i),
        .cfg_ready_o  (cfg_ready_o),
        .cfg_idx_i    (cfg_idx_i),
        .cfg_start_i  (cfg_start_i),
        .cfg_rows_i   (cfg_rows_i),
        .cfg_group_i  (cfg_group_i),
        .cfg_err_o    (cfg_err_o),
        .req_valid_i  (req_valid_i),
        .req_ready_o  (req_ready_o),
        .req_addr_i   (req_addr_i),
        .rsp_valid_o  (rsp_valid_o),
        .rsp_ready_i  (rsp_ready_i),
        .rsp_addr_o   (rsp_addr_o),
        .rsp_region_o (rsp_region_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] a;
        logic [2:0]  r;
        int          c;
    } exp_t;
    exp_t sb[$];

    int n_cmp = 0;
    int n_err = 0;
    int n_pop = 0;
    int occ   = 0;
    bit lat_chk = 0;

    // Reference partition table, filled by cfg_write with its own validity rule.
    bit          pen    [4];
    logic [31:0] pstart [4];
    int          prows  [4];
    int          pgrp   [4];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Stack: word index within tile moves up to the row field, tile id moves down.
    function automatic void model(input logic [31:0] a, output logic [31:0] ea, output logic [2:0] er);
        logic [63:0] off, idx, row, tile, base, lim;
        bit hit;
        hit = 0;
        ea = a;
        er = 3'd0;
        if (a < 32'h0004_0000) begin
            ea = (a & ~32'h0003_FFFF) | (((a >> 6) & 32'h1F) << 13) | (((a >> 11) & 32'h7F) << 6) | (a & 32'h3F);
            er = 3'd1;
        end else begin
            for (int p = 0; p < 4; p++) begin
                base = {32'b0, pstart[p]};
                lim  = base + 64'(prows[p]) * 64'd8192;
                if (!hit && pen[p] && {32'b0, a} >= base && {32'b0, a} < lim) begin
                    hit  = 1;
                    off  = {32'b0, a} - base;
                    idx  = off / 64;
                    row  = (idx / 64'(pgrp[p])) % 64'(prows[p]);
                    tile = (idx % 64'(pgrp[p])) + (idx / (64'(pgrp[p]) * 64'(prows[p]))) * 64'(pgrp[p]);
                    ea   = 32'(base + row * 64'd8192 + tile * 64'd64 + (off % 64));
                    er   = 3'(p + 2);
                end
            end
        end
    endfunction

    // Response monitor: samples on the falling edge, between active edges.
    bit          stalled = 0;
    logic [31:0] hold_a;
    logic [2:0]  hold_r;
    always @(negedge clk) begin
        if (rst_i) begin
            occ     = 0;
            stalled = 0;
        end else begin
            if (stalled) begin
                chk("stall_vld", 64'(rsp_valid_o), 64'd1);
                chk("stall_addr", 64'(rsp_addr_o), 64'(hold_a));
                chk("stall_region", 64'(rsp_region_o), 64'(hold_r));
            end
            if (!cfg_valid_i)
                chk("req_rdy_rule", 64'(req_ready_o), 64'(!(occ == 2 && !rsp_ready_i)));
            if (rsp_valid_o && rsp_ready_i) begin
                if (sb.size() == 0) begin
                    chk("unexpected_rsp", 64'(rsp_addr_o), 64'hDEAD_0000_0000_0000);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    n_pop++;
                    chk("rsp_addr", 64'(rsp_addr_o), 64'(e.a));
                    chk("rsp_region", 64'(rsp_region_o), 64'(e.r));
                    if (lat_chk) chk("latency", 64'(cyc - e.c), 64'd2);
                end
            end
            stalled = rsp_valid_o && !rsp_ready_i;
            hold_a  = rsp_addr_o;
            hold_r  = rsp_region_o;
            occ     = occ + int'(req_valid_i && req_ready_o) - int'(rsp_valid_o && rsp_ready_i);
        end
    end

    // All driver tasks start and end 1 time unit after a rising edge.
    task automatic send_x(input logic [31:0] a, input logic [31:0] ea, input logic [2:0] er);
        bit ok;
        int t;
        exp_t e;
        ok = 0;
        t  = 0;
        req_valid_i = 1'b1;
        req_addr_i  = a;
        while (!ok && t < 100) begin
            @(negedge clk);
            if (req_ready_o) begin
                e.a = ea;
                e.r = er;
                e.c = cyc;
                sb.push_back(e);
                ok = 1;
            end
            @(posedge clk);
            #1;
            t++;
        end
        req_valid_i = 1'b0;
        if (!ok) chk("req_timeout", 64'd0, 64'd1);
    endtask

    task automatic send(input logic [31:0] a);
        logic [31:0] ea;
        logic [2:0]  er;
        model(a, ea, er);
        send_x(a, ea, er);
    endtask

    task automatic table_update(input int idx, input logic [31:0] st, input logic [7:0] rows, input logic [7:0] grp);
        bit v;
        v = (rows == 8'd0) || ($countones(rows) == 1 && $countones(grp) == 1 && grp <= 8'd128 && st[12:0] == 13'd0);
        pen[idx]    = v && rows != 8'd0;
        pstart[idx] = st;
        prows[idx]  = int'(rows);
        pgrp[idx]   = int'(grp);
    endtask

    task automatic cfg_write(input int idx, input logic [31:0] st, input logic [7:0] rows, input logic [7:0] grp);
        bit ok;
        int t;
        ok = 0;
        t  = 0;
        cfg_valid_i = 1'b1;
        cfg_idx_i   = 2'(idx);
        cfg_start_i = st;
        cfg_rows_i  = rows;
        cfg_group_i = grp;
        while (!ok && t < 100) begin
            @(negedge clk);
            if (cfg_ready_o) begin
                table_update(idx, st, rows, grp);
                ok = 1;
            end
            @(posedge clk);
            #1;
            t++;
        end
        cfg_valid_i = 1'b0;
        if (!ok) chk("cfg_timeout", 64'd0, 64'd1);
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while (sb.size() != 0 && t < 200) begin
            @(posedge clk);
            #1;
            t++;
        end
        chk("drain_left", 64'(sb.size()), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int pops0;
        for (int p = 0; p < 4; p++) begin
            pen[p] = 0; pstart[p] = '0; prows[p] = 1; pgrp[p] = 1;
        end
        rst_i = 1'b1; cfg_valid_i = 1'b0; cfg_idx_i = '0; cfg_start_i = '0;
        cfg_rows_i = '0; cfg_group_i = '0; req_valid_i = 1'b0; req_addr_i = '0;
        rsp_ready_i = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst_i = 1'b0;

        // Reset state
        chk("rst_rsp_vld", 64'(rsp_valid_o), 64'd0);
        chk("rst_rsp_addr", 64'(rsp_addr_o), 64'd0);
        chk("rst_rsp_region", 64'(rsp_region_o), 64'd0);
        chk("rst_cfg_err", 64'(cfg_err_o), 64'd0);
        chk("rst_cfg_rdy", 64'(cfg_ready_o), 64'd1);
        chk("rst_req_rdy", 64'(req_ready_o), 64'd1);

        // Stack mapping and stack boundary
        lat_chk = 1;
        send_x(32'h0000_0040, 32'h0000_2000, 3'd1);
        send_x(32'h0000_0800, 32'h0000_0040, 3'd1);
        send(32'h0003_FFFC);
        send(32'h0001_2345);
        send_x(32'h0004_0000, 32'h0004_0000, 3'd0);
        wait_drain();

        // Partition 0: start 0x0010_0000, R = 4, G = 4
        cfg_write(0, 32'h0010_0000, 8'd4, 8'd4);
        chk("p0_cfg_err", 64'(cfg_err_o), 64'd0);
        send_x(32'h0010_0040, 32'h0010_0040, 3'd2);
        send_x(32'h0010_0100, 32'h0010_2000, 3'd2);
        send_x(32'h0010_0400, 32'h0010_0100, 3'd2);
        send(32'h0010_7FFC);
        send(32'h0010_5A84);
        send_x(32'h0010_8000, 32'h0010_8000, 3'd0);
        send_x(32'h000F_FFFC, 32'h000F_FFFC, 3'd0);
        wait_drain();

        // Priority: p0 and p1 both cover 0x0020_0000
        cfg_write(0, 32'h0020_0000, 8'd1, 8'd1);
        cfg_write(1, 32'h0020_0000, 8'd8, 8'd2);
        send_x(32'h0020_0080, 32'h0020_0080, 3'd2);
        wait_drain();
        cfg_write(0, 32'h0000_0000, 8'd0, 8'd0);
        send_x(32'h0020_0080, 32'h0020_2000, 3'd3);
        send(32'h0020_FFFC);
        wait_drain();
        chk("disable_cfg_err", 64'(cfg_err_o), 64'd0);

        // Invalid config
        cfg_write(2, 32'h0040_0000, 8'd2, 8'd2);
        send_x(32'h0040_0080, 32'h0040_2000, 3'd4);
        wait_drain();
        cfg_write(2, 32'h0040_0000, 8'd3, 8'd2);
        chk("bad_rows_err", 64'(cfg_err_o), 64'd1);
        send_x(32'h0040_0080, 32'h0040_0080, 3'd0);
        cfg_write(3, 32'h0060_0000, 8'd2, 8'd3);
        chk("bad_group_err", 64'(cfg_err_o), 64'd1);
        send_x(32'h0060_0000, 32'h0060_0000, 3'd0);
        wait_drain();
        lat_chk = 0;

        // Backpressure: 8 addresses, output ready stalls then toggles
        pops0 = n_pop;
        fork
            begin
                send(32'h0000_0040);
                send(32'h0000_0800);
                send(32'h0003_FFC0);
                send(32'h0020_0080);
                send(32'h0020_01C4);
                send(32'h0020_FFFC);
                send(32'h0021_0000);
                send(32'h1234_5678);
            end
            begin
                rsp_ready_i = 1'b0;
                repeat (4) begin @(posedge clk); #1; end
                repeat (30) begin
                    rsp_ready_i = ~rsp_ready_i;
                    @(posedge clk);
                    #1;
                end
                rsp_ready_i = 1'b1;
            end
        join
        wait_drain();
        chk("bp_count", 64'(n_pop - pops0), 64'd8);

        // Config blocked while requests are in flight
        rsp_ready_i = 1'b0;
        send(32'h0000_0040);
        send(32'h0000_0800);
        cfg_valid_i = 1'b1; cfg_idx_i = 2'd3; cfg_start_i = 32'h0050_0000;
        cfg_rows_i = 8'd1; cfg_group_i = 8'd1;
        repeat (3) begin
            @(negedge clk);
            chk("cfg_rdy_busy", 64'(cfg_ready_o), 64'd0);
            chk("req_rdy_full", 64'(req_ready_o), 64'd0);
            @(posedge clk);
            #1;
        end
        rsp_ready_i = 1'b1;
        begin
            bit ok;
            int t;
            ok = 0;
            t  = 0;
            while (!ok && t < 20) begin
                @(negedge clk);
                if (cfg_ready_o) begin
                    chk("cfg_after_drain", 64'(sb.size()), 64'd0);
                    table_update(3, 32'h0050_0000, 8'd1, 8'd1);
                    ok = 1;
                end
                @(posedge clk);
                #1;
                t++;
            end
            cfg_valid_i = 1'b0;
            if (!ok) chk("cfg_drain_timeout", 64'd0, 64'd1);
        end
        send_x(32'h0050_0040, 32'h0050_0040, 3'd5);
        wait_drain();

        // Simultaneous config and request on an empty pipe
        cfg_valid_i = 1'b1; cfg_idx_i = 2'd2; cfg_start_i = '0;
        cfg_rows_i = 8'd0; cfg_group_i = 8'd0;
        req_valid_i = 1'b1; req_addr_i = 32'h0000_0044;
        @(negedge clk);
        chk("coll_cfg_rdy", 64'(cfg_ready_o), 64'd1);
        chk("coll_req_rdy", 64'(req_ready_o), 64'd0);
        table_update(2, 32'h0, 8'd0, 8'd0);
        @(posedge clk);
        #1;
        cfg_valid_i = 1'b0;
        send_x(32'h0000_0044, 32'h0000_2004, 3'd1);
        wait_drain();

        // Reset in the middle of a stream
        send(32'h0000_0040);
        send(32'h0000_0800);
        rsp_ready_i = 1'b0;
        rst_i = 1'b1;
        sb.delete();
        for (int p = 0; p < 4; p++) pen[p] = 0;
        @(posedge clk);
        #1;
        chk("midrst_rsp_vld", 64'(rsp_valid_o), 64'd0);
        chk("midrst_cfg_err", 64'(cfg_err_o), 64'd0);
        @(posedge clk);
        #1;
        rst_i = 1'b0;
        rsp_ready_i = 1'b1;
        repeat (4) begin @(posedge clk); #1; end
        send_x(32'h0050_0040, 32'h0050_0040, 3'd0);
        send_x(32'h0020_0080, 32'h0020_0080, 3'd0);
        wait_drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/scrambler_partition_pipe.md
# scrambler_partition_pipe

Pipelined, runtime-programmable address scrambler on the core-to-TCDM request path. It generalises the fixed stack-sequential scrambler in three ways: NumPartitions programmable heap partitions, each with its own group factor and row count; a two-stage valid/ready pipeline; and a config write port with validation and error reporting. Output addresses feed the tile/bank decode downstream.

## Interface
- AddrWidth, 32, address width
- ByteOffset, 2, log2 bank width in bytes
- NumTiles, 128, tiles (power of two, ≥2); T = log2(NumTiles)
- NumBanksPerTile, 16, banks per tile (power of two, ≥2); C = ByteOffset + log2(NumBanksPerTile)
- SeqMemSizePerTile, 2048, stack bytes per tile (multiple of 2^C)
- NumPartitions, 4, heap partition table entries (1..8)
- RowSize, derived, 2^(C+T) bytes per full TCDM row
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- cfg_valid_i / cfg_ready_o  in/out  1  config write handshake
- cfg_idx_i  in  clog2(NumPartitions)  entry index
- cfg_start_i  in  AddrWidth  partition base address
- cfg_rows_i  in  8  rows R; 0 disables the entry
- cfg_group_i  in  8  group factor G
- cfg_err_o  out  1  sticky invalid-config flag
- req_valid_i / req_ready_o  in/out  1  input request handshake
- req_addr_i  in  AddrWidth  input address
- rsp_valid_o / rsp_ready_i  out/in  1  output handshake
- rsp_addr_o  out  AddrWidth  scrambled address
- rsp_region_o  out  clog2(NumPartitions+2)  0 = passthrough, 1 = stack, 2+p = partition p

## Operation
- Config write accepted on cfg_valid_i && cfg_ready_o. cfg_ready_o = both pipeline stages empty. In an accept cycle req_ready_o is forced 0: config has priority.
- Entry validity: R ∈ {1,2,4,…,128}; G a power of two with G ≤ NumTiles; cfg_start_i aligned to RowSize.
- Invalid write: entry disabled, cfg_err_o set. cfg_err_o clears only on reset.
- R = 0 is a valid disable write and does not set the error flag.
- A new entry applies to requests accepted from the next cycle onward.
- Region priority, evaluated in stage 1:
  - Stack: addr < NumTiles*SeqMemSizePerTile.
  - Otherwise the lowest-index enabled p with start_p ≤ addr < start_p + R_p*RowSize.
  - Otherwise passthrough.
- Stack mapping: swap fields [C+S-1:C] and [C+S+T-1:C+S], where S = log2(SeqMemSizePerTile) − C. Output field = {addr[C+S-1:C], addr[C+S+T-1:C+S]}. All other bits unchanged.
- Partition mapping, with g = log2 G, r = log2 R, off = addr − start, w = off[C+T+r-1:C]:
  - tile = {w[T+r-1:g+r], w[g-1:0]}
  - row = w[g+r-1:g]
  - out = start + (row << (C+T)) + (tile << C) + off[C-1:0]
- All arithmetic is modulo 2^AddrWidth. The start+size compare uses AddrWidth+1 bits so the limit never wraps.
- Passthrough: out = addr.

## Timing
- Stage 1 registers the address, the region code and the selected entry fields. Stage 2 registers rsp_addr_o and rsp_region_o.
- Latency is 2 cycles from req accept to rsp_valid_o. Throughput is 1 per cycle under continuous rsp_ready_i.
- A stage loads when it is empty or advancing. req_ready_o = !s1_valid || s1_advance, gated by a config accept. The ready path is combinational.
- rsp_addr_o and rsp_region_o hold stable while rsp_valid_o && !rsp_ready_i.
- Reset values: all entries disabled, cfg_err_o = 0, rsp_valid_o = 0, rsp_addr_o = 0, rsp_region_o = 0, cfg_ready_o = 1, req_ready_o = 1 (in the cycle after reset).
- Reset mid-operation discards in-flight requests with no output.
- Both stages full and rsp_ready_i = 0: req_ready_o = 0. No request is dropped or duplicated.

## Test plan
- Stack mapping (default params): req 0x0000_0040 -> rsp 0x0000_2000, region 1, 2 cycles after accept; req 0x0000_0800 -> 0x0000_0040.
- Partition mapping: program p0 start 0x0010_0000, R = 4, G = 4. Then:
  - req 0x0010_0040 -> 0x0010_0040
  - req 0x0010_0100 -> 0x0010_2000
  - req 0x0010_0400 -> 0x0010_0100
  - all region 2
  - req 0x0010_8000 -> passthrough, region 0
- Priority and disable: p0 and p1 both cover 0x0020_0000; rsp_region_o = 2. Write p0 R = 0, then the same address -> region 3, cfg_err_o stays 0.
- Invalid config: write R = 3 -> cfg_err_o = 1 next cycle, entry disabled. Write G = 3 on another entry -> entry disabled, cfg_err_o still 1.
- Backpressure: stream 8 addresses with rsp_ready_i toggling 1/0. Required: all 8 responses in order, no loss or duplicates, outputs stable while stalled, req_ready_o = 0 only when both stages are full.
- Config/request collision and reset: cfg_valid_i with a pipeline in flight -> cfg_ready_o = 0 until drained. Simultaneous cfg and req on an empty pipe -> cfg accepted, req_ready_o = 0 that cycle. rst_i asserted mid-stream -> rsp_valid_o = 0 next cycle, entries disabled.
